// File: rtl/sample_arb.sv
// sample_arb: shares one SRAM write port among NREQ samplers, writing one frame of SRAM_DEPTH words per enable.
// Define SAMPLE_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module sample_arb #(
  parameter int DATAWIDTH  = 32,
  parameter int SAMPLEADDR = 16,
  parameter int NREQ       = 4,
  parameter int SRAM_DEPTH = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_enable,
  input  logic [NREQ-1:0]           i_req,
  input  logic [NREQ*DATAWIDTH-1:0] i_wdata,
  output logic [NREQ-1:0]           o_gnt,
  output logic                      o_sram_we,
  output logic [SAMPLEADDR-1:0]     o_sram_addr,
  output logic [DATAWIDTH-1:0]      o_sram_wdata,
  output logic                      o_sram_full,
  output logic                      o_busy,
  output logic                      o_done
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = SAMPLEADDR + 1;
  typedef enum logic [1:0] {IDLE, ARB, WRITE, DONE} state_t;
  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_win, w_win;
  logic [SAMPLEADDR-1:0] r_addr;
  logic [DATAWIDTH-1:0]  r_data;
  logic                  r_full;
  logic                  w_any, w_last, w_grant;
  assign w_any   = |i_req;
  assign w_last  = r_cnt == CW'(SRAM_DEPTH - 1);
  assign w_grant = r_state == ARB && w_any;
`ifdef SAMPLE_ARB_RR_EN
  logic [IW-1:0] r_ptr;
  // descending scan: the last hit is the requester closest after r_ptr
  always_comb begin
    int j;
    j = 0;
    w_win = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = int'(r_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (i_req[j]) w_win = IW'(j);
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_ptr <= IW'(NREQ - 1);
    else if (w_grant) r_ptr <= w_win;
`else
  always_comb begin
    w_win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (i_req[k]) w_win = IW'(k);
  end
`endif
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = i_enable ? ARB : IDLE;
      ARB:     w_next = w_any ? WRITE : ARB;
      WRITE:   w_next = w_last ? DONE : ARB;
      default: w_next = IDLE;
    endcase
  end
  // address and data are captured at the grant so they hold steady through and after the write
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_win  <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_full <= 1'b0;
    end else begin
      if (r_state == IDLE && i_enable) begin
        r_cnt  <= '0;
        r_full <= 1'b0;
      end
      if (w_grant) begin
        r_win  <= w_win;
        r_addr <= r_cnt[SAMPLEADDR-1:0];
        r_data <= i_wdata[int'(w_win)*DATAWIDTH +: DATAWIDTH];
      end
      if (r_state == WRITE) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_full <= 1'b1;
      end
    end
  assign o_gnt        = (r_state == WRITE) ? NREQ'(1) << r_win : '0;
  assign o_sram_we    = r_state != WRITE;
  assign o_sram_addr  = r_addr;
  assign o_sram_wdata = r_data;
  assign o_sram_full  = r_full;
  assign o_busy       = r_state != IDLE;
  assign o_done       = r_state == DONE;
endmodule

// File: tb/tb_sample_arb.sv
// tb_sample_arb: vector table, hand sequences and random traffic against a frame-level model; two DUTs (depth 4 and 16).
module tb_sample_arb;
  logic         clk = 0;
  logic         rst_n = 0;
  logic         en = 0;
  logic [3:0]   req = '0;
  logic [127:0] wdata = '0;
  logic [3:0]   gnt [2];
  logic         we [2];
  logic [15:0]  addr [2];
  logic [31:0]  wd [2];
  logic         full [2];
  logic         busy [2];
  logic         done [2];
  int n_chk = 0;
  int n_err = 0;
  bit mon_en = 0;
  always #5 clk = ~clk;
  sample_arb #(.SRAM_DEPTH(4)) u_d4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_req(req), .i_wdata(wdata),
    .o_gnt(gnt[0]), .o_sram_we(we[0]), .o_sram_addr(addr[0]), .o_sram_wdata(wd[0]),
    .o_sram_full(full[0]), .o_busy(busy[0]), .o_done(done[0]));
  sample_arb #(.SRAM_DEPTH(16)) u_d16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_req(req), .i_wdata(wdata),
    .o_gnt(gnt[1]), .o_sram_we(we[1]), .o_sram_addr(addr[1]), .o_sram_wdata(wd[1]),
    .o_sram_full(full[1]), .o_busy(busy[1]), .o_done(done[1]));
  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d got=%h want=%h @%0t", nm, d, act, exp, $time);
    end
  endtask
  // frame-level model: a frame is an ordered run of writes; the scheduled write (pend) happens one cycle after the grant
  typedef struct {
    bit          arb;
    bit          dn;
    int          pend;
    int          cnt;
    bit          full;
    int          ptr;
    logic [15:0] addr;
    logic [31:0] data;
  } mstate_t;
  mstate_t m [2];
  int depth [2] = '{4, 16};
  function automatic int pick(int ptr, logic [3:0] rq);
`ifdef SAMPLE_ARB_RR_EN
    for (int k = 1; k <= 4; k++) if (rq[(ptr + k) % 4]) return (ptr + k) % 4;
`else
    for (int i = 0; i < 4; i++) if (rq[i]) return i;
`endif
    return -1;
  endfunction
  function automatic mstate_t mreset();
    mstate_t s;
    s.arb = 0; s.dn = 0; s.pend = -1; s.cnt = 0; s.full = 0; s.ptr = 3; s.addr = '0; s.data = '0;
    return s;
  endfunction
  function automatic mstate_t step(mstate_t s, int dep, bit e, logic [3:0] rq, logic [127:0] wv);
    mstate_t n;
    int w;
    n = s;
    if (s.dn) n.dn = 0;
    else if (s.pend >= 0) begin
      if (s.cnt == dep - 1) begin n.full = 1; n.dn = 1; end
      else n.arb = 1;
      n.cnt = s.cnt + 1;
      n.pend = -1;
    end else if (s.arb) begin
      if (rq != 0) begin
        w = pick(s.ptr, rq);
        n.pend = w; n.addr = 16'(s.cnt); n.data = wv[w*32 +: 32]; n.arb = 0; n.ptr = w;
      end
    end else if (e) begin
      n.arb = 1; n.cnt = 0; n.full = 0;
    end
    return n;
  endfunction
  always @(posedge clk or negedge rst_n)
    for (int d = 0; d < 2; d++)
      m[d] <= !rst_n ? mreset() : step(m[d], depth[d], en, req, wdata);
  always @(negedge clk)
    if (mon_en)
      for (int d = 0; d < 2; d++) begin
        chk("m_gnt", d, 32'(gnt[d]), m[d].pend >= 0 ? 32'(4'b0001 << m[d].pend) : 32'd0);
        chk("m_we", d, 32'(we[d]), 32'(m[d].pend < 0));
        chk("m_addr", d, 32'(addr[d]), 32'(m[d].addr));
        chk("m_wdata", d, wd[d], m[d].data);
        chk("m_full", d, 32'(full[d]), 32'(m[d].full));
        chk("m_busy", d, 32'(busy[d]), 32'(m[d].arb || m[d].pend >= 0 || m[d].dn));
        chk("m_done", d, 32'(done[d]), 32'(m[d].dn));
      end
  typedef struct {
    bit          en;
    logic [3:0]  rq;
    logic [3:0]  gnt;
    bit          we;
    int          addr;
    logic [31:0] wd;
    bit          busy;
    bit          done;
    bit          full;
  } vec_t;
  vec_t tbl [13];
  logic [3:0] e1 [5];
  logic [3:0] e2 [4];
  task automatic apply_reset();
    rst_n = 0; en = 0; req = '0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask
  task automatic wait_write(int d, output bit ok);
    ok = 0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(posedge clk); #1;
      if (we[d] === 1'b0) ok = 1;
    end
  endtask
  initial begin
    bit ok;
    logic [31:0] wv;
    localparam logic [31:0] W = 32'hA5A5_0001;
    tbl[0]  = '{1'b1, 4'b0001, 4'b0000, 1'b1, 0, 32'h0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0001, 4'b0001, 1'b0, 0, W, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'b0001, 4'b0000, 1'b1, 0, W, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'b0001, 4'b0001, 1'b0, 1, W, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 1, W, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'b0001, 4'b0001, 1'b0, 2, W, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 2, W, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'b0001, 4'b0001, 1'b0, 3, W, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 3, W, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 4'b0001, 4'b0000, 1'b1, 3, W, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 4'b0001, 4'b0000, 1'b1, 3, W, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 3, W, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'b0001, 4'b0001, 1'b0, 0, W, 1'b1, 1'b0, 1'b0};
`ifdef SAMPLE_ARB_RR_EN
    e1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    e2 = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
`else
    e1 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    e2 = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
`endif
    wdata = {32'hA5A5_0004, 32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001};
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_gnt", d, 32'(gnt[d]), 0);
      chk("rst_we", d, 32'(we[d]), 1);
      chk("rst_addr", d, 32'(addr[d]), 0);
      chk("rst_wdata", d, wd[d], 0);
      chk("rst_full", d, 32'(full[d]), 0);
      chk("rst_busy", d, 32'(busy[d]), 0);
      chk("rst_done", d, 32'(done[d]), 0);
    end
    mon_en = 1;
    rst_n = 1;
    for (int i = 0; i < 13; i++) begin
      en = tbl[i].en; req = tbl[i].rq;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_gnt", i), 0, 32'(gnt[0]), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_we", i), 0, 32'(we[0]), 32'(tbl[i].we));
      chk($sformatf("tbl%0d_addr", i), 0, 32'(addr[0]), tbl[i].addr);
      chk($sformatf("tbl%0d_wdata", i), 0, wd[0], tbl[i].wd);
      chk($sformatf("tbl%0d_busy", i), 0, 32'(busy[0]), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), 0, 32'(done[0]), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_full", i), 0, 32'(full[0]), 32'(tbl[i].full));
    end
    apply_reset();
    en = 1; req = 4'b1111;
    @(posedge clk); #1;
    en = 0;
    for (int n = 0; n < 5; n++) begin
      wait_write(1, ok);
      chk("all_wait", 1, 32'(ok), 1);
      chk("all_gnt", 1, 32'(gnt[1]), 32'(e1[n]));
      chk("all_addr", 1, 32'(addr[1]), n);
      wv = 32'hA5A5_0001 + 32'($clog2(int'(e1[n])));
      chk("all_wdata", 1, wd[1], wv);
    end
    apply_reset();
    en = 1; req = 4'b1010;
    @(posedge clk); #1;
    en = 0;
    for (int n = 0; n < 4; n++) begin
      wait_write(1, ok);
      chk("odd_wait", 1, 32'(ok), 1);
      chk("odd_gnt", 1, 32'(gnt[1]), 32'(e2[n]));
      chk("odd_addr", 1, 32'(addr[1]), n);
    end
    apply_reset();
    en = 1; req = 4'b0001;
    @(posedge clk); #1;
    en = 0;
    for (int n = 0; n < 3; n++) begin
      wait_write(1, ok);
      chk("abort_wait", 1, 32'(ok), 1);
    end
    chk("abort_addr", 1, 32'(addr[1]), 2);
    #2 rst_n = 0;
    #1;
    chk("abort_we", 1, 32'(we[1]), 1);
    chk("abort_gnt", 1, 32'(gnt[1]), 0);
    chk("abort_busy", 1, 32'(busy[1]), 0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("abort_nodone", 1, 32'(done[1]), 0);
      chk("abort_nowrite", 1, 32'(we[1]), 1);
    end
    en = 1;
    @(posedge clk); #1;
    en = 0;
    wait_write(1, ok);
    chk("restart_wait", 1, 32'(ok), 1);
    chk("restart_addr", 1, 32'(addr[1]), 0);
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      en = $urandom_range(0, 9) == 0;
      req = 4'($urandom);
      wdata = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 0;
        #2 rst_n = 1;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sample_arb.md
SAMPLE_ARB -- requirements
Module: sample_arb

Interface
REQ-001 Parameter DATAWIDTH, 32, width of one sample word.
REQ-002 Parameter SAMPLEADDR, 16, sample SRAM address width.
REQ-003 Parameter NREQ, 4, number of sampling requesters sharing the SRAM write port.
REQ-004 Parameter SRAM_DEPTH, 1024, words per frame; SHALL satisfy 2 <= SRAM_DEPTH <= 2**SAMPLEADDR.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  frame start request, sampled only in IDLE.
REQ-008 req  input  NREQ  per-requester "sample valid"; held until its gnt bit.
REQ-009 wdata  input  NREQ*DATAWIDTH  per-requester sample; slice i belongs to req[i].
REQ-010 gnt  output  NREQ  one-hot, one-cycle acknowledge: sample i was written.
REQ-011 sram_we  output  1  SRAM write strobe, active-low.
REQ-012 sram_addr  output  SAMPLEADDR  SRAM write address.
REQ-013 sram_wdata  output  DATAWIDTH  SRAM write data.
REQ-014 sram_full  output  1  frame buffer full flag.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle frame-complete pulse.

Function
REQ-017 FSM states IDLE, ARB, WRITE, DONE; IDLE->ARB when enable=1; ARB->WRITE when any req bit=1, else stay ARB; WRITE->DONE if the written address equals SRAM_DEPTH-1, else WRITE->ARB; DONE->IDLE unconditionally.
REQ-018 On IDLE->ARB the write counter SHALL clear to 0 and sram_full SHALL clear.
REQ-019 In ARB with any req, the winner index and its wdata slice SHALL be registered on the ARB->WRITE edge.
REQ-020 In WRITE: sram_we=0, sram_addr=counter, sram_wdata=latched word, gnt[winner]=1; all other gnt bits 0.
REQ-021 Counter SHALL increment by 1 on each WRITE cycle; no wrap within a frame.
REQ-022 Latency: req seen in ARB -> gnt and write exactly 1 cycle later; peak throughput one write per 2 cycles.
REQ-023 A req deasserted after the ARB latch edge SHALL still be written and granted.
REQ-024 sram_full SHALL rise on the edge leaving the WRITE of address SRAM_DEPTH-1 and hold until the next IDLE->ARB transition.
REQ-025 done=1 only in DONE, exactly one cycle per frame.
REQ-026 enable outside IDLE SHALL be ignored; enable seen in DONE SHALL NOT start a frame.
REQ-027 Outside WRITE: sram_we=1, gnt=0; sram_addr and sram_wdata hold last values.

Reset
REQ-028 rst=0 SHALL asynchronously force state IDLE, counter 0, sram_full 0, done 0, busy 0, gnt 0, sram_we 1, sram_addr 0, sram_wdata 0, priority pointer NREQ-1.
REQ-029 Reset mid-frame SHALL abort without any further write; no done pulse is issued for the aborted frame.

Configuration
REQ-030 Macro SAMPLE_ARB_RR_EN defined: round-robin; search starts at (last winner+1) mod NREQ, pointer updated on every grant.
REQ-031 Macro SAMPLE_ARB_RR_EN undefined: fixed priority, lowest index with req=1 wins; pointer logic absent.

Verification
REQ-032 Reset, then enable=1 for one cycle with req=4'b0001, wdata[0]=0xA5A5_0001 -> gnt=4'b0001 and sram_we=0 at sram_addr=0 two cycles after enable; busy=1.
REQ-033 RR build, req=4'b1111 held constantly -> gnt sequence 0001,0010,0100,1000,0001 on successive WRITE cycles; sram_addr 0,1,2,3,4.
REQ-034 Non-RR build, req=4'b1010 held -> every gnt = 4'b0010.
REQ-035 SRAM_DEPTH=4, req=4'b0001 held -> four writes at addresses 0..3, done=1 for one cycle after address 3, sram_full=1 until the next enable, no fifth write.
REQ-036 rst=0 asserted during WRITE at address 2 -> same cycle sram_we=1, gnt=0, busy=0; no done; next enable restarts at address 0.
REQ-037 enable pulsed during ARB and during DONE -> no counter clear, no new frame; FSM returns to IDLE after DONE.
